// File: rtl/multiplicador_serial.sv
// Serial 4x4 unsigned shift-and-add multiplier, one add-and-shift step per clock.
// Optional: define MULT_PARADA_ANTECIPADA_EN to leave CALCULA as soon as the remaining multiplier bits are zero.

module quatro_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_entrada,
    output logic [3:0] soma,
    output logic       c_saida
);
    logic w_c1, w_c2, w_c3;

    assign soma[0] = a[0] ^ b[0] ^ c_entrada;
    assign w_c1    = (a[0] & b[0]) | (c_entrada & (a[0] ^ b[0]));
    assign soma[1] = a[1] ^ b[1] ^ w_c1;
    assign w_c2    = (a[1] & b[1]) | (w_c1 & (a[1] ^ b[1]));
    assign soma[2] = a[2] ^ b[2] ^ w_c2;
    assign w_c3    = (a[2] & b[2]) | (w_c2 & (a[2] ^ b[2]));
    assign soma[3] = a[3] ^ b[3] ^ w_c3;
    assign c_saida = (a[3] & b[3]) | (w_c3 & (a[3] ^ b[3]));
endmodule

module multiplicador_serial (
    input  logic       clock,
    input  logic       reset,
    input  logic       inicio,
    input  logic [0:3] a,
    input  logic [0:3] b,
    output logic [0:7] produto,
    output logic       pronto,
    output logic       ocupado
);
    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        PRONTO  = 2'd2
    } t_estado;

    t_estado    r_estado;
    logic [3:0] r_multiplicando;
    logic [7:0] r_acc;
    logic [1:0] r_contador;
    logic [7:0] r_produto;
    logic       r_pronto;
    logic       r_ocupado;

    logic [3:0] w_a;
    logic [3:0] w_b;
    logic [3:0] w_soma;
    logic       w_c_saida;
    logic [3:0] w_alta;
    logic       w_carry;
    logic [7:0] w_desloc;
    logic [7:0] w_final;
    logic       w_fim;

    // Ports use index 0 as LSB; internally everything is a normal [N-1:0] vector.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < 4; i++) begin
            w_a[i] = a[i];
            w_b[i] = b[i];
        end
        produto = '0;
        for (int i = 0; i < 8; i++) begin
            produto[i] = r_produto[i];
        end
    end

    quatro_bit u_somador (
        .a         (r_acc[7:4]),
        .b         (r_multiplicando),
        .c_entrada (1'b0),
        .soma      (w_soma),
        .c_saida   (w_c_saida)
    );

    // One step: conditional add into the high half, then {carry, high, low} >> 1.
    assign w_alta   = r_acc[0] ? w_soma    : r_acc[7:4];
    assign w_carry  = r_acc[0] ? w_c_saida : 1'b0;
    assign w_desloc = {w_carry, w_alta, r_acc[3:1]};

`ifdef MULT_PARADA_ANTECIPADA_EN
    logic [1:0] w_restantes;
    logic [7:0] w_mascara;

    // After this step, the low w_restantes bits still hold unprocessed multiplier bits.
    assign w_restantes = 2'd3 - r_contador;
    assign w_mascara   = (8'd1 << w_restantes) - 8'd1;
    assign w_fim       = ((w_desloc & w_mascara) == 8'd0);
    assign w_final     = w_desloc >> w_restantes;
`else
    assign w_fim   = (r_contador == 2'd3);
    assign w_final = w_desloc;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado        <= OCIOSO;
            r_multiplicando <= '0;
            r_acc           <= '0;
            r_contador      <= '0;
            r_produto       <= '0;
            r_pronto        <= 1'b0;
            r_ocupado       <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    r_pronto <= 1'b0;
                    if (inicio) begin
                        r_multiplicando <= w_a;
                        r_acc           <= {4'b0000, w_b};
                        r_contador      <= '0;
                        r_ocupado       <= 1'b1;
                        r_estado        <= CALCULA;
                    end else begin
                        r_ocupado <= 1'b0;
                    end
                end
                CALCULA: begin
                    r_acc      <= w_desloc;
                    r_contador <= r_contador + 2'd1;
                    if (w_fim) begin
                        r_produto <= w_final;
                        r_pronto  <= 1'b1;
                        r_estado  <= PRONTO;
                    end
                end
                PRONTO: begin
                    r_pronto  <= 1'b0;
                    r_ocupado <= 1'b0;
                    r_estado  <= OCIOSO;
                end
                default: begin
                    r_pronto  <= 1'b0;
                    r_ocupado <= 1'b0;
                    r_estado  <= OCIOSO;
                end
            endcase
        end
    end

    assign pronto  = r_pronto;
    assign ocupado = r_ocupado;
endmodule

// File: doc/multiplicador_serial.md
MULTIPLICADOR_SERIAL -- requirements
Module: multiplicador_serial

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: single system clock, all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port inicio, input, 1 bit: start request, sampled on rising edge of clock.
REQ-004 The block SHALL have port a, input, [0:3]: multiplicand, unsigned, index 0 = LSB.
REQ-005 The block SHALL have port b, input, [0:3]: multiplier, unsigned, index 0 = LSB.
REQ-006 The block SHALL have port produto, output, [0:7]: unsigned product a*b, index 0 = LSB.
REQ-007 The block SHALL have port pronto, output, 1 bit: one-cycle pulse, produto valid.
REQ-008 The block SHALL have port ocupado, output, 1 bit: high while a multiplication is in progress.

Function
REQ-009 The block SHALL implement a shift-and-add multiplier with states OCIOSO, CALCULA, PRONTO.
REQ-010 The block SHALL perform the add step with one instance of the team's 4-bit ripple adder (quatro_bit), c_entrada tied to 0.
REQ-011 In OCIOSO with inicio=1 at an edge, the block SHALL latch a into the multiplicand register, load b into the low half of the accumulator, clear the high half and the carry, clear the step counter, and go to CALCULA.
REQ-012 In OCIOSO with inicio=0, the block SHALL hold all registers, produto keeping its last value.
REQ-013 Per CALCULA edge: if accumulator bit 0 = 1, high half := high half + multiplicand with carry-out captured, else carry := 0 and high half unchanged; then {carry, high, low} SHALL shift right one bit.
REQ-014 After the 4th CALCULA edge, the block SHALL go to PRONTO; produto SHALL equal a*b (0..225) from that edge on.
REQ-015 pronto SHALL be 1 exactly in the PRONTO cycle; the next edge SHALL return to OCIOSO unconditionally.
REQ-016 Latency SHALL be 5 edges from the edge accepting inicio to pronto=1 (without macro).
REQ-017 ocupado SHALL be 1 in CALCULA and PRONTO, 0 in OCIOSO.
REQ-018 inicio SHALL be ignored in CALCULA and PRONTO; a and b changes after acceptance SHALL not affect the result.
REQ-019 produto SHALL hold its value in OCIOSO until the next accepted inicio.

Reset
REQ-020 reset=1 SHALL immediately, without clock, force state OCIOSO, produto=0, pronto=0, ocupado=0, step counter=0, carry=0, multiplicand=0.
REQ-021 Reset asserted mid-operation SHALL abort it; no pronto pulse SHALL follow for the aborted operation.
REQ-022 The first inicio SHALL be accepted on the first rising edge with reset=0.

Configuration
REQ-023 With macro MULT_PARADA_ANTECIPADA_EN defined, CALCULA SHALL exit to PRONTO early once all unprocessed multiplier bits are 0, with the remaining shifts applied in that same transition so produto is still exact.
REQ-024 With MULT_PARADA_ANTECIPADA_EN defined and b=0, the block SHALL go from the acceptance edge to PRONTO at the next edge (latency 2).
REQ-025 Without MULT_PARADA_ANTECIPADA_EN, latency SHALL always be exactly 5 edges, independent of b.

Verification
REQ-026 a=15, b=15, inicio pulse -> pronto=1 exactly 5 edges later, produto=225, ocupado=1 during the 4 intervening cycles.
REQ-027 a=13, b=11 -> produto=143; then a=9, b=0 -> produto=0, 5-edge latency without macro.
REQ-028 Hold inicio=1 continuously with a=3, b=5 -> back-to-back results 15 with pronto every 6th cycle; a changed to 7 mid-op -> result still 15.
REQ-029 Reset asserted 2 edges after acceptance of a=6, b=7 -> produto=0, ocupado=0 at once, no pronto; next run a=6, b=7 -> 42.
REQ-030 MULT_PARADA_ANTECIPADA_EN defined: a=3, b=2 -> produto=6, pronto 3 edges after acceptance; a=5, b=8 -> 40 in 5 edges.
